// File: rtl/mem_fill_if.sv
// Handshake and RAM-port bundle for mem_fill_engine.
// master = controller/arbiter side, slave = the fill engine.
interface mem_fill_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] fill_value;
  logic              done_ack;
  logic              mem_grant;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              busy;
  logic              init_done;
  logic              verify_err;

  modport master (
    output start, mode, base_addr, length, fill_value, done_ack, mem_grant, mem_rdata,
    input  mem_addr, mem_wdata, mem_wren, busy, init_done, verify_err
  );

  modport slave (
    input  start, mode, base_addr, length, fill_value, done_ack, mem_grant, mem_rdata,
    output mem_addr, mem_wdata, mem_wren, busy, init_done, verify_err
  );
endinterface

// File: rtl/mem_fill_engine.sv
// Pattern fill sequencer over a wrapping address window of a shared single-port RAM.
// Define MEM_FILL_VERIFY_EN to add a readback-verify pass after the fill.
module mem_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic     clk,
  input  logic     reset_n,
  mem_fill_if.slave bus
);

`ifdef MEM_FILL_VERIFY_EN
  typedef enum logic [2:0] {IDLE, FILL, WAIT, DONE, VERIFY, VDRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;
`endif

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  index;
  logic [DATA_W-1:0] fill_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              last;

  // Same address/pattern generator serves both the fill and the verify walk.
  assign addr = base_q + ADDR_W'(index);
  assign last = (index == len_q - LEN_W'(1));

  always_comb begin
    case (mode_q)
      2'b00:   data = DATA_W'(addr);
      2'b01:   data = fill_q;
      2'b10:   data = fill_q + DATA_W'(index);
      default: data = DATA_W'(addr) ^ fill_q;
    endcase
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = data;
  assign bus.mem_wren  = (state == FILL) && bus.mem_grant;
  assign bus.busy      = busy_q;
  assign bus.init_done = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      index  <= '0;
      mode_q <= '0;
      base_q <= '0;
      len_q  <= '0;
      fill_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          base_q <= bus.base_addr;
          len_q  <= bus.length;
          fill_q <= bus.fill_value;
          index  <= '0;
          busy_q <= 1'b1;
          state  <= (bus.length == '0) ? WAIT : FILL;
        end
        FILL: if (bus.mem_grant) begin
          if (last) state <= WAIT;
          else      index <= index + LEN_W'(1);
        end
        // Gap cycle so the final write has landed before done or readback.
        WAIT: begin
`ifdef MEM_FILL_VERIFY_EN
          if (len_q != '0) begin
            state <= VERIFY;
            index <= '0;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
`else
          state  <= DONE;
          done_q <= 1'b1;
`endif
        end
`ifdef MEM_FILL_VERIFY_EN
        VERIFY: if (bus.mem_grant) begin
          if (last) state <= VDRAIN;
          else      index <= index + LEN_W'(1);
        end
        VDRAIN: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
`endif
        DONE: if (bus.done_ack) begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_FILL_VERIFY_EN
  // Stage 0 is the read issue; stage STAGES lines up with mem_rdata.
  localparam int STAGES = 1;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0][DATA_W-1:0]   exp_pipe;
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0][DATA_W-1:0] exp_q;
  logic                          err_q;

  assign vld_pipe = {vld_q, (state == VERIFY) && bus.mem_grant};
  assign exp_pipe = {exp_q, data};
  assign bus.verify_err = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      exp_q <= exp_pipe[STAGES-1:0];
      if (state == IDLE && bus.start)
        err_q <= 1'b0;
      else if (vld_pipe[STAGES] && (bus.mem_rdata != exp_pipe[STAGES]))
        err_q <= 1'b1;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata   = ^bus.mem_rdata;
  assign bus.verify_err = 1'b0;
`endif

endmodule
